// File: rtl/pa_clic_pkg.sv
// Shared constants for the CLIC priority arbiter: FSM state encoding and default sizing.
package pa_clic_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int DEF_SEL_NUM   = 64;
    localparam int DEF_CTL_WIDTH = 8;
    localparam int DEF_GRP_NUM   = 8;
    localparam int DEF_ID_WIDTH  = 6;

endpackage

// File: rtl/pa_clic_arb_grp.sv
// Combinational GRP_NUM-way maximum finder over one group of interrupt sources;
// equal levels resolve to the lowest local index.
module pa_clic_arb_grp #(
    parameter int CTL_WIDTH = 8,
    parameter int GRP_NUM   = 8,
    parameter int GID_W     = 3
) (
    input  logic [GRP_NUM-1:0]           grp_pending,
    input  logic [GRP_NUM-1:0]           grp_enable,
    input  logic [GRP_NUM*CTL_WIDTH-1:0] grp_ctl,
    input  logic [CTL_WIDTH-1:0]         int_thresh,
    output logic                         group_found,
    output logic [CTL_WIDTH-1:0]         group_level,
    output logic [GID_W-1:0]             group_idx
);

    always_comb begin
        group_found = 1'b0;
        group_level = '0;
        group_idx   = '0;
        for (int i = 0; i < GRP_NUM; i++) begin
            // Strict compare keeps the earlier index on equal levels.
            if (grp_pending[i] && grp_enable[i] &&
                (grp_ctl[i*CTL_WIDTH +: CTL_WIDTH] > int_thresh) &&
                (!group_found || (grp_ctl[i*CTL_WIDTH +: CTL_WIDTH] > group_level))) begin
                group_found = 1'b1;
                group_level = grp_ctl[i*CTL_WIDTH +: CTL_WIDTH];
                group_idx   = GID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pa_clic_arb_scan.sv
// Multi-cycle CLIC priority arbiter: scans one group per cycle, publishes a registered winner.
// Optional macro PA_CLIC_ARB_LOCK_EN: a held, unacked winner is only replaced by a strictly higher level.
module pa_clic_arb_scan
    import pa_clic_pkg::*;
#(
    parameter int SEL_NUM   = DEF_SEL_NUM,
    parameter int CTL_WIDTH = DEF_CTL_WIDTH,
    parameter int GRP_NUM   = DEF_GRP_NUM,
    parameter int ID_WIDTH  = DEF_ID_WIDTH
) (
    input  logic                         forever_cpuclk,
    input  logic                         cpurst_b,
    input  logic [SEL_NUM-1:0]           int_pending,
    input  logic [SEL_NUM-1:0]           int_enable,
    input  logic [CTL_WIDTH*SEL_NUM-1:0] int_ctl,
    input  logic [CTL_WIDTH-1:0]         int_thresh,
    input  logic                         arb_start,
    input  logic                         core_ack,
    output logic [SEL_NUM-1:0]           arb_sel_onehot,
    output logic [ID_WIDTH-1:0]          arb_id,
    output logic [CTL_WIDTH-1:0]         arb_level,
    output logic                         arb_vld,
    output logic                         arb_busy
);

    localparam int GRP_CNT = SEL_NUM / GRP_NUM;
    localparam int CNT_W   = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1;
    localparam int GID_W   = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GRP_CNT - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     grp_cnt;
    logic                 best_found;
    logic [CTL_WIDTH-1:0] best_level;
    logic [ID_WIDTH-1:0]  best_id;
    logic                 grp_found;
    logic [CTL_WIDTH-1:0] grp_level;
    logic [GID_W-1:0]     grp_idx;
    logic [ID_WIDTH-1:0]  grp_gid;
    logic                 grp_take;
    logic                 publish_ok;
    logic [SEL_NUM-1:0]   best_onehot;

    pa_clic_arb_grp #(
        .CTL_WIDTH (CTL_WIDTH),
        .GRP_NUM   (GRP_NUM),
        .GID_W     (GID_W)
    ) u_grp (
        .grp_pending (int_pending[int'(grp_cnt)*GRP_NUM +: GRP_NUM]),
        .grp_enable  (int_enable[int'(grp_cnt)*GRP_NUM +: GRP_NUM]),
        .grp_ctl     (int_ctl[int'(grp_cnt)*GRP_NUM*CTL_WIDTH +: GRP_NUM*CTL_WIDTH]),
        .int_thresh  (int_thresh),
        .group_found (grp_found),
        .group_level (grp_level),
        .group_idx   (grp_idx)
    );

    assign grp_gid  = ID_WIDTH'(int'(grp_cnt) * GRP_NUM + int'(grp_idx));
    // Across groups only a strictly higher level displaces the earlier winner.
    assign grp_take = (state == ST_SCAN) && !arb_start && grp_found &&
                      (!best_found || (grp_level > best_level));
    assign best_onehot = best_found ? (SEL_NUM'(1) << best_id) : '0;
    assign arb_busy    = (state != ST_IDLE);

`ifdef PA_CLIC_ARB_LOCK_EN
    assign publish_ok = !arb_vld || (best_found && (best_level > arb_level));
`else
    assign publish_ok = 1'b1;
`endif

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state      <= ST_IDLE;
            grp_cnt    <= '0;
            best_found <= 1'b0;
        end else if (arb_start) begin
            // Start (or restart from SCAN/DONE) always begins at group 0 with no candidate.
            state      <= ST_SCAN;
            grp_cnt    <= '0;
            best_found <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (grp_take)
                        best_found <= 1'b1;
                    if (grp_cnt == LAST_GRP)
                        state <= ST_DONE;
                    else
                        grp_cnt <= grp_cnt + 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (arb_start) begin
            best_level <= '0;
            best_id    <= '0;
        end else if (grp_take) begin
            best_level <= grp_level;
            best_id    <= grp_gid;
        end
    end

    // Publish in DONE wins over a same-cycle ack, which is then dropped.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            arb_vld        <= 1'b0;
            arb_sel_onehot <= '0;
            arb_id         <= '0;
            arb_level      <= '0;
        end else if (state == ST_DONE) begin
            if (publish_ok) begin
                arb_vld        <= best_found;
                arb_sel_onehot <= best_onehot;
                arb_id         <= best_id;
                arb_level      <= best_level;
            end
        end else if (core_ack && arb_vld) begin
            arb_vld        <= 1'b0;
            arb_sel_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_pa_clic_arb_scan.sv
// Directed plus randomized bench for pa_clic_arb_scan against a whole-vector priority model.
module tb_pa_clic_arb_scan;

    logic         clk = 1'b0;
    logic         cpurst_b;
    logic [63:0]  int_pending;
    logic [63:0]  int_enable;
    logic [511:0] int_ctl;
    logic [7:0]   int_thresh;
    logic         arb_start;
    logic         core_ack;
    logic [63:0]  arb_sel_onehot;
    logic [5:0]   arb_id;
    logic [7:0]   arb_level;
    logic         arb_vld;
    logic         arb_busy;

    int checks   = 0;
    int failures = 0;

    bit         e_vld;
    int         e_id;
    logic [7:0] e_lvl;

    always #5 clk = ~clk;

    pa_clic_arb_scan dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .int_pending    (int_pending),
        .int_enable     (int_enable),
        .int_ctl        (int_ctl),
        .int_thresh     (int_thresh),
        .arb_start      (arb_start),
        .core_ack       (core_ack),
        .arb_sel_onehot (arb_sel_onehot),
        .arb_id         (arb_id),
        .arb_level      (arb_level),
        .arb_vld        (arb_vld),
        .arb_busy       (arb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl_of(input int i);
        logic [7:0] v;
        v = int_ctl[i*8 +: 8];
        return v;
    endfunction

    // Highest qualifying level first, then the lowest index carrying that level.
    task automatic model_winner(output bit f, output int id, output logic [7:0] lvl);
        int top;
        top = -1;
        f = 0; id = 0; lvl = 8'h00;
        for (int i = 0; i < 64; i++)
            if (int_pending[i] && int_enable[i] && ctl_of(i) > int_thresh && int'(ctl_of(i)) > top)
                top = int'(ctl_of(i));
        if (top >= 0) begin
            f = 1;
            lvl = 8'(top);
            for (int i = 63; i >= 0; i--)
                if (int_pending[i] && int_enable[i] && int'(ctl_of(i)) == top)
                    id = i;
        end
    endtask

    task automatic model_publish();
        bit f; int id; logic [7:0] l;
        model_winner(f, id, l);
`ifdef PA_CLIC_ARB_LOCK_EN
        if (e_vld && !(f && l > e_lvl)) return;
`endif
        e_vld = f; e_id = id; e_lvl = l;
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_vld"}, 64'(arb_vld), 64'(e_vld));
        chk({tag, "_id"}, 64'(arb_id), 64'(e_id));
        chk({tag, "_lvl"}, 64'(arb_level), 64'(e_lvl));
        chk({tag, "_onehot"}, arb_sel_onehot, e_vld ? (64'd1 << e_id) : 64'd0);
    endtask

    task automatic clear_srcs();
        int_pending = '0; int_enable = '0; int_ctl = '0; int_thresh = 8'h00;
    endtask

    task automatic set_src(input int i, input logic [7:0] v);
        int_pending[i] = 1'b1; int_enable[i] = 1'b1; int_ctl[i*8 +: 8] = v;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_scan(input string tag, input bit ack_in_done);
        arb_start = 1'b1;
        tick();
        arb_start = 1'b0;
        chk({tag, "_busy_scan"}, 64'(arb_busy), 64'd1);
        repeat (8) tick();
        check_out({tag, "_pre"});
        core_ack = ack_in_done;
        tick();
        core_ack = 1'b0;
        model_publish();
        check_out(tag);
        chk({tag, "_busy_idle"}, 64'(arb_busy), 64'd0);
    endtask

    task automatic do_ack(input string tag);
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        e_vld = 0;
        check_out(tag);
    endtask

    initial begin
        cpurst_b = 1'b0; arb_start = 1'b0; core_ack = 1'b0;
        clear_srcs();
        e_vld = 0; e_id = 0; e_lvl = 8'h00;
        #12;
        check_out("reset");
        chk("reset_busy", 64'(arb_busy), 64'd0);
        @(negedge clk) cpurst_b = 1'b1;
        tick();

        set_src(37, 8'h40);
        run_scan("single", 1'b0);
        chk("single_id37", 64'(arb_id), 64'd37);
        do_ack("single_ack");
        do_ack("idle_ack");

        clear_srcs(); set_src(5, 8'h80); set_src(50, 8'h80);
        run_scan("tie", 1'b0);
        chk("tie_id5", 64'(arb_id), 64'd5);
        do_ack("tie_ack");
        int_ctl[50*8 +: 8] = 8'h81;
        run_scan("tie81", 1'b0);
        chk("tie81_id50", 64'(arb_id), 64'd50);
        do_ack("tie81_ack");

        clear_srcs(); set_src(3, 8'h10); int_thresh = 8'h10;
        int_pending[9] = 1'b1; int_ctl[9*8 +: 8] = 8'hF0;
        run_scan("thresh", 1'b0);
        chk("thresh_vld0", 64'(arb_vld), 64'd0);

        // Restart at cycle 4: nothing may be published at cycle 9.
        clear_srcs(); set_src(20, 8'h33);
        arb_start = 1'b1; tick(); arb_start = 1'b0;
        repeat (3) tick();
        arb_start = 1'b1; tick(); arb_start = 1'b0;
        repeat (5) tick();
        check_out("restart_c9");
        repeat (3) tick();
        check_out("restart_c12");
        tick();
        model_publish();
        check_out("restart_c13");
        chk("restart_id20", 64'(arb_id), 64'd20);
        do_ack("restart_ack");

        // Held winner versus lower/higher rescans, with an ack colliding with the publish.
        clear_srcs(); set_src(1, 8'h40);
        run_scan("lock_base", 1'b0);
        clear_srcs(); set_src(2, 8'h20);
        run_scan("lock_low", 1'b1);
`ifdef PA_CLIC_ARB_LOCK_EN
        chk("lock_low_kept", 64'(arb_level), 64'h40);
`else
        chk("lock_low_over", 64'(arb_level), 64'h20);
`endif
        clear_srcs(); set_src(3, 8'h60);
        run_scan("lock_high", 1'b0);
        chk("lock_high_lvl", 64'(arb_level), 64'h60);
        do_ack("lock_ack");

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) do_ack("rnd_ack");
            int_pending = {$urandom, $urandom};
            int_enable  = {$urandom, $urandom};
            for (int i = 0; i < 64; i++) int_ctl[i*8 +: 8] = 8'($urandom_range(0, 7) << 5);
            int_thresh = 8'($urandom_range(0, 4) << 5);
            run_scan("rnd", 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a scan with a held winner.
        clear_srcs(); set_src(60, 8'h90);
        if (arb_vld) do_ack("pre_rst_ack");
        run_scan("pre_rst", 1'b0);
        arb_start = 1'b1; tick(); arb_start = 1'b0;
        repeat (2) tick();
        @(negedge clk); cpurst_b = 1'b0; #1;
        e_vld = 0; e_id = 0; e_lvl = 8'h00;
        check_out("midrst");
        chk("midrst_busy", 64'(arb_busy), 64'd0);
        @(negedge clk) cpurst_b = 1'b1;
        repeat (10) tick();
        check_out("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
